// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb -- decode-stage register file with per-register busy scoreboard
//
// Purpose:
//   2**ADDRESS_WIDTH x DATA_WIDTH register file with NUM_READ independent
//   combinational read ports, one writeback port, and a busy bit per
//   register. Issue marks a destination busy; writeback writes the data and
//   clears busy. A flush clears every busy bit. x0 reads 0 and is never busy.
//   busy_cnt_o is a registered count of the busy registers.
//
// Configuration:
//   REGFILE_BYPASS_EN  defined   -> writeback data/busy forwarded to the read
//                                   ports in the same cycle.
//                      undefined -> reads return stored state only.
//
// Ports:
//   clk, rst_n            clock (posedge), async active-low reset
//   AD_i  / RD_o          read addresses / read data, port k = slice k
//   busy_o                busy bit of each read port's source register
//   WE3_i, AD3_i, WD3_i   writeback enable, address, data
//   issue_i, issue_rd_i   issued instruction's destination register
//   flush_i               clear all busy bits
//   busy_cnt_o            number of busy registers
//   a0_o                  regs[A0_INDEX] for test/debug
// ---------------------------------------------------------------------------
module regfile_sb #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_READ      = 2,
  parameter int A0_INDEX      = 10
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_READ*ADDRESS_WIDTH-1:0] AD_i,
  output logic [NUM_READ*DATA_WIDTH-1:0]    RD_o,
  output logic [NUM_READ-1:0]               busy_o,
  input  logic                              WE3_i,
  input  logic [ADDRESS_WIDTH-1:0]          AD3_i,
  input  logic [DATA_WIDTH-1:0]             WD3_i,
  input  logic                              issue_i,
  input  logic [ADDRESS_WIDTH-1:0]          issue_rd_i,
  input  logic                              flush_i,
  output logic [ADDRESS_WIDTH:0]            busy_cnt_o,
  output logic [DATA_WIDTH-1:0]             a0_o
);

  localparam int NUM_REGS = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH:0] CNT_MAX = ADDRESS_WIDTH'(NUM_REGS - 1);

  logic [DATA_WIDTH-1:0]    r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]      r_busy;
  logic [ADDRESS_WIDTH:0]   r_busy_cnt;

  logic                     w_wr_en;   // writeback to a real register
  logic                     w_set_en;  // issue to a real register
  logic                     w_inc;
  logic                     w_dec;
  logic [NUM_REGS-1:0]      w_busy_nxt;
  logic [ADDRESS_WIDTH:0]   w_cnt_nxt;

  // x0 is hard-wired: writes and issues that target it are dropped here.
  assign w_wr_en  = WE3_i   && (AD3_i      != '0);
  assign w_set_en = issue_i && (issue_rd_i != '0);

  // Counter moves only on real 0->1 / 1->0 transitions. When the same
  // register is issued and retired together, the issue wins, so that
  // retire is not a 1->0 transition.
  assign w_inc = w_set_en && !r_busy[issue_rd_i];
  assign w_dec = w_wr_en  &&  r_busy[AD3_i] &&
                 !(w_set_en && (issue_rd_i == AD3_i));

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_busy_nxt = r_busy;
    w_cnt_nxt  = r_busy_cnt;
    if (flush_i) begin
      w_busy_nxt = '0;
      w_cnt_nxt  = '0;
    end else begin
      if (w_wr_en)  w_busy_nxt[AD3_i]      = 1'b0;
      if (w_set_en) w_busy_nxt[issue_rd_i] = 1'b1;
      if (w_inc && !w_dec && (r_busy_cnt != CNT_MAX))
        w_cnt_nxt = r_busy_cnt + 1'b1;
      else if (w_dec && !w_inc && (r_busy_cnt != '0))
        w_cnt_nxt = r_busy_cnt - 1'b1;
    end
  end

  // NOTE: the register array is cleared by the async reset because the
  // core relies on every register reading 0 immediately after reset; this
  // costs a reset net on every flop and rules out RAM inference.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      r_regs[AD3_i] <= WD3_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_cnt_nxt;
    end
  end

  assign busy_cnt_o = r_busy_cnt;
  assign a0_o       = r_regs[A0_INDEX];

  // Read ports: fully independent combinational lookups.
  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDRESS_WIDTH-1:0] w_ad;
    logic                     w_nz;
    assign w_ad = AD_i[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign w_nz = (w_ad != '0);

`ifdef REGFILE_BYPASS_EN
    logic w_fwd;
    assign w_fwd = WE3_i && (AD3_i == w_ad) && w_nz;

    always_comb begin
      RD_o[k*DATA_WIDTH +: DATA_WIDTH] = w_nz ? r_regs[w_ad] : '0;
      busy_o[k]                        = w_nz && r_busy[w_ad];
      if (w_fwd) begin
        RD_o[k*DATA_WIDTH +: DATA_WIDTH] = WD3_i;
        // Retiring producer hides busy unless a new producer issues now.
        busy_o[k] = issue_i && (issue_rd_i == w_ad) && !flush_i;
      end
    end
`else
    assign RD_o[k*DATA_WIDTH +: DATA_WIDTH] = w_nz ? r_regs[w_ad] : '0;
    assign busy_o[k]                        = w_nz && r_busy[w_ad];
`endif
  end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR*AW-1:0]  AD_i;
  logic [NR*DW-1:0]  RD_o;
  logic [NR-1:0]     busy_o;
  logic              WE3_i;
  logic [AW-1:0]     AD3_i;
  logic [DW-1:0]     WD3_i;
  logic              issue_i;
  logic [AW-1:0]     issue_rd_i;
  logic              flush_i;
  logic [AW:0]       busy_cnt_o;
  logic [DW-1:0]     a0_o;

  int checks = 0;
  int errors = 0;

  regfile_sb #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR), .A0_INDEX(10)) dut (
    .clk(clk), .rst_n(rst_n), .AD_i(AD_i), .RD_o(RD_o), .busy_o(busy_o),
    .WE3_i(WE3_i), .AD3_i(AD3_i), .WD3_i(WD3_i), .issue_i(issue_i),
    .issue_rd_i(issue_rd_i), .flush_i(flush_i), .busy_cnt_o(busy_cnt_o),
    .a0_o(a0_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    WE3_i = 1'b0; issue_i = 1'b0; flush_i = 1'b0;
    AD3_i = '0; WD3_i = '0; issue_rd_i = '0;
  endtask

  function automatic logic [DW-1:0] rd(input int k);
    return RD_o[k*DW +: DW];
  endfunction

  task automatic set_ad(input int k, input logic [AW-1:0] a);
    AD_i[k*AW +: AW] = a;
  endtask

  initial begin
    rst_n = 1'b0; AD_i = '0; idle();
    #12;
    check("reset_cnt", 64'(busy_cnt_o), 64'd0);
    check("reset_a0",  64'(a0_o), 64'd0);
    rst_n = 1'b1;

    // 1: write x5 and x10, issue x6, then async reset mid-cycle.
    step();
    WE3_i = 1'b1; AD3_i = 5'd5; WD3_i = 32'hDEADBEEF; step();
    AD3_i = 5'd10; WD3_i = 32'h77; issue_i = 1'b1; issue_rd_i = 5'd6; step();
    idle(); set_ad(0, 5'd5); #1;
    check("pre_rst_rd0", 64'(rd(0)), 64'hDEADBEEF);
    check("pre_rst_a0",  64'(a0_o), 64'h77);
    check("pre_rst_cnt", 64'(busy_cnt_o), 64'd1);
    rst_n = 1'b0; #1;
    check("async_rst_rd0", 64'(rd(0)), 64'd0);
    check("async_rst_a0",  64'(a0_o), 64'd0);
    check("async_rst_cnt", 64'(busy_cnt_o), 64'd0);
    #1 rst_n = 1'b1;

    // 2: issue x7, next cycle retire x7=0x1234.
    step();
    issue_i = 1'b1; issue_rd_i = 5'd7; step();
    idle(); set_ad(0, 5'd7); #1;
    check("t2_busy_set", 64'(busy_o[0]), 64'd1);
    check("t2_cnt_1",    64'(busy_cnt_o), 64'd1);
    WE3_i = 1'b1; AD3_i = 5'd7; WD3_i = 32'h1234; #1;
`ifdef REGFILE_BYPASS_EN
    check("t2_byp_busy", 64'(busy_o[0]), 64'd0);
    check("t2_byp_rd",   64'(rd(0)), 64'h1234);
`else
    check("t2_nobyp_busy", 64'(busy_o[0]), 64'd1);
    check("t2_nobyp_rd",   64'(rd(0)), 64'd0);
`endif
    step(); idle(); #1;
    check("t2_busy_clr", 64'(busy_o[0]), 64'd0);
    check("t2_cnt_0",    64'(busy_cnt_o), 64'd0);
    check("t2_rd",       64'(rd(0)), 64'h1234);

    // 3: x3 busy, then issue x3 and retire x3 in the same cycle.
    issue_i = 1'b1; issue_rd_i = 5'd3; step();
    check("t3_cnt_1", 64'(busy_cnt_o), 64'd1);
    WE3_i = 1'b1; AD3_i = 5'd3; WD3_i = 32'h55; step();
    idle(); set_ad(1, 5'd3); #1;
    check("t3_busy_kept", 64'(busy_o[1]), 64'd1);
    check("t3_cnt_same",  64'(busy_cnt_o), 64'd1);
    check("t3_rd",        64'(rd(1)), 64'h55);
    WE3_i = 1'b1; AD3_i = 5'd3; WD3_i = 32'h56; step(); idle(); #1;
    check("t3_retire_cnt", 64'(busy_cnt_o), 64'd0);

    // 4: x0 write/issue are no-ops; same address on both ports.
    WE3_i = 1'b1; AD3_i = 5'd0; WD3_i = 32'hFFFF;
    issue_i = 1'b1; issue_rd_i = 5'd0; step();
    idle(); set_ad(0, 5'd0); set_ad(1, 5'd0); #1;
    check("t4_rd0_x0",   64'(rd(0)), 64'd0);
    check("t4_rd1_x0",   64'(rd(1)), 64'd0);
    check("t4_busy_x0",  64'(busy_o[0]), 64'd0);
    check("t4_cnt",      64'(busy_cnt_o), 64'd0);
    set_ad(0, 5'd3); set_ad(1, 5'd3); #1;
    check("t4_same_addr", 64'(rd(1)), 64'(rd(0)) & 64'h0 | 64'h56);
    check("t4_same_p0",   64'(rd(0)), 64'h56);

    // 5: issue x1,x2,x3 then flush + issue x4 + writeback x1.
    issue_i = 1'b1; issue_rd_i = 5'd1; step();
    issue_rd_i = 5'd2; step();
    issue_rd_i = 5'd3; step();
    idle(); #1;
    check("t5_cnt_3", 64'(busy_cnt_o), 64'd3);
    flush_i = 1'b1; issue_i = 1'b1; issue_rd_i = 5'd4;
    WE3_i = 1'b1; AD3_i = 5'd1; WD3_i = 32'h11; step();
    idle(); set_ad(0, 5'd4); set_ad(1, 5'd1); #1;
    check("t5_cnt_0",    64'(busy_cnt_o), 64'd0);
    check("t5_x4_idle",  64'(busy_o[0]), 64'd0);
    check("t5_x1_idle",  64'(busy_o[1]), 64'd0);
    check("t5_x1_data",  64'(rd(1)), 64'h11);

    // Different registers issued/retired together, re-issue, idle retire.
    issue_i = 1'b1; issue_rd_i = 5'd8; step();
    WE3_i = 1'b1; AD3_i = 5'd8; WD3_i = 32'h8; issue_rd_i = 5'd9; step();
    idle(); set_ad(0, 5'd9); set_ad(1, 5'd8); #1;
    check("mix_cnt",    64'(busy_cnt_o), 64'd1);
    check("mix_x9",     64'(busy_o[0]), 64'd1);
    check("mix_x8",     64'(busy_o[1]), 64'd0);
    issue_i = 1'b1; issue_rd_i = 5'd9; step();
    idle(); #1;
    check("reissue_cnt", 64'(busy_cnt_o), 64'd1);
    WE3_i = 1'b1; AD3_i = 5'd12; WD3_i = 32'hC; step();
    idle(); #1;
    check("idle_wb_cnt", 64'(busy_cnt_o), 64'd1);

    // 6: write x10 while port 0 reads it.
    set_ad(0, 5'd10);
    WE3_i = 1'b1; AD3_i = 5'd10; WD3_i = 32'hA5A5; #1;
`ifdef REGFILE_BYPASS_EN
    check("t6_same_cycle", 64'(rd(0)), 64'hA5A5);
`else
    check("t6_same_cycle", 64'(rd(0)), 64'd0);
`endif
    check("t6_a0_old", 64'(a0_o), 64'd0);
    step(); idle(); #1;
    check("t6_rd_next", 64'(rd(0)), 64'hA5A5);
    check("t6_a0_next", 64'(a0_o), 64'hA5A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
